drive_mission_sequencer: RTL and testbench

- Top-level drive-train scheduler for the match.
- Sequences the ball-search and goal-direction controllers in alternating rounds and hands each an Enable level.
- Shares the single motor-driver interface between them by muxing the active controller's direction and duty bits onto the H-bridge/PWM outputs.
- Forces a coast gap between phases, and optionally faults a phase that never reports Done.

---
 rtl/drive_mission_sequencer.sv | 127 ++++++++++++
 tb/tb_drive_mission_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/drive_mission_sequencer.sv
// drive_mission_sequencer: alternates search/goal phases with coast gaps and muxes the active controller onto the motor driver.
// Define DMS_WATCHDOG_EN to fault any phase that never reports Done within TIMEOUT_CYC cycles.
module drive_mission_sequencer #(
    parameter int SETTLE_CYC  = 10_000_000,
    parameter int ROUNDS      = 3,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Start,
    input  logic       Abort,
    input  logic       Pause,
    input  logic       Search_Done,
    input  logic       Goal_Done,
    input  logic [3:0] Search_Dir,
    input  logic [3:0] Search_Duty,
    input  logic [3:0] Goal_Dir,
    input  logic [3:0] Goal_Duty,
    output logic       Search_En,
    output logic       Goal_En,
    output logic [3:0] Dir,
    output logic [3:0] Duty,
    output logic [2:0] State,
    output logic [3:0] Round,
    output logic       Busy,
    output logic       Mission_Done,
    output logic       Fault
);
    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        SEARCH   = 3'b001,
        SETTLE_A = 3'b010,
        GOAL     = 3'b011,
        SETTLE_B = 3'b100,
        COMPLETE = 3'b101,
        FAULT    = 3'b110
    } state_t;

    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_t state, state_n;
    logic [SW-1:0] cnt;
    logic st_cur, st_prev, sd_cur, sd_prev, gd_cur, gd_prev, s_pend, g_pend;
    logic st_rise, s_rise, g_rise, s_evt, g_evt, settle_hit, wd_hit, run_search, run_goal;

    assign st_rise    = st_cur & ~st_prev;
    assign s_rise     = sd_cur & ~sd_prev;
    assign g_rise     = gd_cur & ~gd_prev;
    assign s_evt      = s_rise | s_pend;
    assign g_evt      = g_rise | g_pend;
    assign settle_hit = cnt == SW'(SETTLE_CYC - 1);
    assign run_search = !Pause && state == SEARCH && state_n == SEARCH;
    assign run_goal   = !Pause && state == GOAL && state_n == GOAL;
    assign State      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Done beats the watchdog when both land on the same cycle
    always_comb begin
        state_n = state;
        if (Abort) state_n = IDLE;
        else if (!Pause) begin
            case (state)
                IDLE, COMPLETE: state_n = st_rise ? SEARCH : state;
                SEARCH:         state_n = s_evt ? SETTLE_A : wd_hit ? FAULT : SEARCH;
                SETTLE_A:       state_n = settle_hit ? GOAL : SETTLE_A;
                GOAL:           state_n = g_evt ? SETTLE_B : wd_hit ? FAULT : GOAL;
                SETTLE_B:       state_n = !settle_hit ? SETTLE_B : (Round + 4'd1 < 4'(ROUNDS)) ? SEARCH : COMPLETE;
                default:        state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {st_prev, st_cur, sd_prev, sd_cur, gd_prev, gd_cur} <= '0;
            {s_pend, g_pend} <= '0;
            cnt          <= '0;
            Round        <= '0;
            Search_En    <= 1'b0;
            Goal_En      <= 1'b0;
            Dir          <= '0;
            Duty         <= '0;
            Busy         <= 1'b0;
            Mission_Done <= 1'b0;
        end else begin
            {st_prev, st_cur} <= {st_cur, Start};
            {sd_prev, sd_cur} <= {sd_cur, Search_Done};
            {gd_prev, gd_cur} <= {gd_cur, Goal_Done};
            // rises seen while paused are replayed on the first unpaused cycle
            s_pend <= !Abort && Pause && (s_pend | s_rise);
            g_pend <= !Abort && Pause && (g_pend | g_rise);
            if (Abort || state_n != state) cnt <= '0;
            else if (!Pause && (state == SETTLE_A || state == SETTLE_B)) cnt <= cnt + 1'b1;
            if (Abort) Round <= '0;
            else if ((state == IDLE || state == COMPLETE) && state_n == SEARCH) Round <= '0;
            else if (state == SETTLE_B && state_n != SETTLE_B) Round <= Round + 4'd1;
            Search_En    <= state_n == SEARCH;
            Goal_En      <= state_n == GOAL;
            Dir          <= run_search ? Search_Dir : run_goal ? Goal_Dir : 4'b0000;
            Duty         <= run_search ? Search_Duty : run_goal ? Goal_Duty : 4'b0000;
            Busy         <= state_n == SEARCH || state_n == SETTLE_A || state_n == GOAL || state_n == SETTLE_B;
            Mission_Done <= state_n == COMPLETE;
        end
    end

`ifdef DMS_WATCHDOG_EN
    logic [28:0] wd;
    assign wd_hit = wd == 29'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd    <= '0;
            Fault <= 1'b0;
        end else begin
            if (Abort || state_n != state) wd <= '0;
            else if (!Pause && (state == SEARCH || state == GOAL)) wd <= wd + 29'd1;
            Fault <= state_n == FAULT;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign Fault  = 1'b0;
`endif
endmodule

// File: tb/tb_drive_mission_sequencer.sv
// tb_drive_mission_sequencer: directed checks of sequencing, drive mux, stale Done, pause, abort, reset and watchdog.
module tb_drive_mission_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic Start = 0, Abort = 0, Pause = 0, Search_Done = 0, Goal_Done = 0;
    logic [3:0] Search_Dir = 4'b1001, Search_Duty = 4'b0101, Goal_Dir = 4'b0110, Goal_Duty = 4'b1010;
    logic Search_En, Goal_En, Busy, Mission_Done, Fault;
    logic [3:0] Dir, Duty, Round;
    logic [2:0] State;
    int checks = 0, errors = 0;

    drive_mission_sequencer #(.SETTLE_CYC(4), .ROUNDS(2), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort), .Pause(Pause),
        .Search_Done(Search_Done), .Goal_Done(Goal_Done),
        .Search_Dir(Search_Dir), .Search_Duty(Search_Duty), .Goal_Dir(Goal_Dir), .Goal_Duty(Goal_Duty),
        .Search_En(Search_En), .Goal_En(Goal_En), .Dir(Dir), .Duty(Duty), .State(State),
        .Round(Round), .Busy(Busy), .Mission_Done(Mission_Done), .Fault(Fault)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
        int n = 0;
        while (State !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (State !== s) begin errors++; $display("FAIL %s: State=%b expected %b within %0d cycles", nm, State, s, lim); end
    endtask

    task automatic test_reset;
        {Start, Abort, Pause, Search_Done, Goal_Done} = '0;
        rst_n = 1'b0;
        step(2);
        checks++; if (State !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", State); end
        checks++; if ({Search_En, Goal_En, Busy, Mission_Done, Fault} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {Search_En, Goal_En, Busy, Mission_Done, Fault}); end
        checks++; if ({Dir, Duty, Round} !== 12'h000) begin errors++; $display("FAIL reset_drive: got %h expected 000", {Dir, Duty, Round}); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_full_mission;
        int n;
        Start = 1'b1;
        step(2);
        checks++; if (State !== 3'b001 || Search_En !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL start_search: State=%b En=%b Busy=%b expected 001 1 1", State, Search_En, Busy); end
        checks++; if (Dir !== 4'b0000) begin errors++; $display("FAIL mux_entry_latency: Dir=%b expected 0000", Dir); end
        step(1);
        checks++; if (Dir !== 4'b1001 || Duty !== 4'b0101) begin errors++; $display("FAIL mux_search: Dir=%b Duty=%b expected 1001 0101", Dir, Duty); end
        step(6);
        Search_Done = 1'b1;
        step(1);
        checks++; if (State !== 3'b001) begin errors++; $display("FAIL search_hold: State=%b expected 001", State); end
        step(1);
        checks++; if (State !== 3'b010 || Dir !== 4'b0000 || Search_En !== 1'b0) begin errors++; $display("FAIL settle_a_entry: State=%b Dir=%b En=%b expected 010 0000 0", State, Dir, Search_En); end
        n = 0;
        while (State === 3'b010 && n < 20) begin n++; step(1); end
        checks++; if (n !== 4) begin errors++; $display("FAIL settle_a_len: got %0d cycles expected 4", n); end
        checks++; if (State !== 3'b011 || Goal_En !== 1'b1 || Dir !== 4'b0000) begin errors++; $display("FAIL goal_entry: State=%b En=%b Dir=%b expected 011 1 0000", State, Goal_En, Dir); end
        step(1);
        checks++; if (Dir !== 4'b0110 || Duty !== 4'b1010) begin errors++; $display("FAIL mux_goal: Dir=%b Duty=%b expected 0110 1010", Dir, Duty); end
        Search_Done = 1'b0;
        step(8);
        Goal_Done = 1'b1;
        step(2);
        checks++; if (State !== 3'b100) begin errors++; $display("FAIL settle_b_entry: State=%b expected 100", State); end
        Goal_Done = 1'b0;
        n = 0;
        while (State === 3'b100 && n < 20) begin n++; step(1); end
        checks++; if (n !== 4 || State !== 3'b001 || Round !== 4'd1) begin errors++; $display("FAIL round1: cycles=%0d State=%b Round=%0d expected 4 001 1", n, State, Round); end
        step(3);
        Search_Done = 1'b1;
        wait_state(3'b010, 5, "r2_settle_a");
        wait_state(3'b011, 10, "r2_goal");
        step(2);
        Goal_Done = 1'b1;
        wait_state(3'b100, 5, "r2_settle_b");
        wait_state(3'b101, 10, "complete");
        checks++; if (Round !== 4'd2 || Mission_Done !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL complete_flags: Round=%0d Done=%b Busy=%b expected 2 1 0", Round, Mission_Done, Busy); end
        checks++; if ({Search_En, Goal_En, Dir, Duty} !== 10'b0) begin errors++; $display("FAIL complete_drive: got %b expected 0", {Search_En, Goal_En, Dir, Duty}); end
        {Start, Search_Done, Goal_Done} = '0;
        step(2);
    endtask

    task automatic test_stale_done;
        Goal_Done = 1'b1;
        Start = 1'b1;
        wait_state(3'b001, 5, "restart_search");
        checks++; if (Round !== 4'd0) begin errors++; $display("FAIL restart_round: Round=%0d expected 0", Round); end
        Search_Done = 1'b1;
        wait_state(3'b011, 15, "stale_goal");
        step(5);
        checks++; if (State !== 3'b011) begin errors++; $display("FAIL stale_ignored: State=%b expected 011", State); end
        Goal_Done = 1'b0;
        step(2);
        checks++; if (State !== 3'b011) begin errors++; $display("FAIL stale_fall: State=%b expected 011", State); end
        Goal_Done = 1'b1;
        step(1);
        checks++; if (State !== 3'b011) begin errors++; $display("FAIL stale_rise_lat: State=%b expected 011", State); end
        step(1);
        checks++; if (State !== 3'b100) begin errors++; $display("FAIL stale_fresh_rise: State=%b expected 100", State); end
        {Goal_Done, Search_Done} = '0;
        wait_state(3'b001, 10, "stale_next_search");
    endtask

    task automatic test_pause;
        logic ok = 1'b1;
        Search_Done = 1'b1;
        wait_state(3'b010, 5, "pause_settle_a");
        step(2);
        Pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (State !== 3'b010 || Dir !== 4'b0000) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pause_hold: State=%b Dir=%b expected 010 0000", State, Dir); end
        Pause = 1'b0;
        step(1);
        checks++; if (State !== 3'b010) begin errors++; $display("FAIL pause_resume1: State=%b expected 010", State); end
        step(1);
        checks++; if (State !== 3'b011) begin errors++; $display("FAIL pause_resume2: State=%b expected 011", State); end
        step(1);
        checks++; if (Dir !== 4'b0110) begin errors++; $display("FAIL pause_goal_dir: Dir=%b expected 0110", Dir); end
        Pause = 1'b1;
        step(1);
        checks++; if (Dir !== 4'b0000 || Duty !== 4'b0000 || Goal_En !== 1'b1 || State !== 3'b011) begin errors++; $display("FAIL pause_goal: Dir=%b Duty=%b En=%b State=%b expected 0000 0000 1 011", Dir, Duty, Goal_En, State); end
        Goal_Done = 1'b1;
        step(3);
        checks++; if (State !== 3'b011) begin errors++; $display("FAIL pause_latch_hold: State=%b expected 011", State); end
        Pause = 1'b0;
        step(1);
        checks++; if (State !== 3'b100) begin errors++; $display("FAIL pause_latched_done: State=%b expected 100", State); end
        {Goal_Done, Search_Done} = '0;
        wait_state(3'b101, 10, "pause_complete");
    endtask

    task automatic test_abort;
        Start = 1'b0;
        step(2);
        Start = 1'b1;
        wait_state(3'b001, 5, "abort_search1");
        Search_Done = 1'b1;
        wait_state(3'b011, 15, "abort_goal1");
        Search_Done = 1'b0;
        step(2);
        Goal_Done = 1'b1;
        wait_state(3'b100, 5, "abort_settle_b");
        Goal_Done = 1'b0;
        wait_state(3'b001, 10, "abort_search2");
        checks++; if (Round !== 4'd1) begin errors++; $display("FAIL abort_pre_round: Round=%0d expected 1", Round); end
        Search_Done = 1'b1;
        wait_state(3'b011, 15, "abort_goal2");
        step(2);
        Goal_Done = 1'b1;
        step(1);
        Abort = 1'b1;
        step(1);
        checks++; if (State !== 3'b000 || Round !== 4'd0) begin errors++; $display("FAIL abort_state: State=%b Round=%0d expected 000 0", State, Round); end
        checks++; if ({Search_En, Goal_En, Busy, Dir, Duty} !== 11'b0) begin errors++; $display("FAIL abort_outputs: got %b expected 0", {Search_En, Goal_En, Busy, Dir, Duty}); end
        Abort = 1'b0;
        step(2);
        checks++; if (State !== 3'b000) begin errors++; $display("FAIL abort_stays_idle: State=%b expected 000", State); end
        {Goal_Done, Search_Done, Start} = '0;
        step(2);
    endtask

    task automatic test_async_reset;
        Start = 1'b1;
        wait_state(3'b001, 5, "ar_search");
        step(1);
        checks++; if (Dir !== 4'b1001) begin errors++; $display("FAIL ar_pre_dir: Dir=%b expected 1001", Dir); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({State, Search_En, Busy, Dir, Duty} !== 13'b0) begin errors++; $display("FAIL async_reset: got %b expected 0", {State, Search_En, Busy, Dir, Duty}); end
        Start = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_watchdog;
        int n = 0;
        Start = 1'b1;
        wait_state(3'b001, 5, "wd_search");
`ifdef DMS_WATCHDOG_EN
        while (State === 3'b001 && n < 40) begin n++; step(1); end
        checks++; if (n !== 20 || State !== 3'b110) begin errors++; $display("FAIL wd_timeout: cycles=%0d State=%b expected 20 110", n, State); end
        checks++; if (Fault !== 1'b1 || Search_En !== 1'b0 || Busy !== 1'b0 || Dir !== 4'b0000) begin errors++; $display("FAIL wd_outputs: Fault=%b En=%b Busy=%b Dir=%b expected 1 0 0 0000", Fault, Search_En, Busy, Dir); end
        Start = 1'b0;
        step(2);
        Start = 1'b1;
        step(3);
        checks++; if (State !== 3'b110) begin errors++; $display("FAIL wd_start_ignored: State=%b expected 110", State); end
`else
        step(30);
        checks++; if (State !== 3'b001 || Fault !== 1'b0) begin errors++; $display("FAIL no_watchdog: State=%b Fault=%b expected 001 0", State, Fault); end
`endif
        Abort = 1'b1;
        step(1);
        checks++; if (State !== 3'b000 || Fault !== 1'b0) begin errors++; $display("FAIL wd_abort: State=%b Fault=%b expected 000 0", State, Fault); end
        {Abort, Start} = '0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_full_mission();
        test_stale_done();
        test_pause();
        test_abort();
        test_async_reset();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
